// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and averaging constants.
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALL   = 2'd2
  } state_e;

  // Number of captures averaged per published result, and the matching shift.
  localparam int unsigned AVG_N     = 4;
  localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input plus a one-cycle rising-edge pulse.
// clr returns every flop to zero, so a rise in progress is discarded.
import period_meter_pkg::*;

module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the input through the synchroniser and keep the previous synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d = sync_q[SYNC_STAGES-1];
    if (clr) begin
      sync_d = '0;
      prev_d = 1'b0;
    end
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts system-clock cycles between rising edges of an asynchronous
// input and publishes each count on a valid/ready output with sticky overrun and
// a stall flag. Optional feature macro: PERIOD_METER_AVG_EN publishes the mean
// of every four captures instead of each capture.
import period_meter_pkg::*;

module period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  input  logic             PERIOD_READY,
  output logic             OVERRUN,
  output logic             STALLED
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             stalled_q, stalled_d;

  logic             rise;
  logic             capture;
  logic             publish;
  logic [CNT_W-1:0] pub_val;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .sig_in(SIG_IN),
    .rise  (rise)
  );

  // Next-state, counter and stall flag; capture marks an edge-to-edge measurement.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stalled_d = stalled_q;
    capture   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = ONE_C;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          cnt_d   = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = ST_STALL;
          stalled_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_STALL: begin
        if (rise) begin
          state_d   = ST_MEASURE;
          cnt_d     = ONE_C;
          stalled_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (CLR) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      stalled_d = 1'b0;
    end
  end

`ifdef PERIOD_METER_AVG_EN
  logic [CNT_W+1:0] acc_q, acc_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W+1:0] sum;

  // Accumulate captures; every fourth one publishes the truncated mean and restarts.
  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    publish = 1'b0;
    sum     = acc_q + {2'b00, cnt_q};
    pub_val = sum[AVG_SHIFT +: CNT_W];
    if (capture) begin
      if (idx_q == 2'(AVG_N - 1)) begin
        publish = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
      end else begin
        acc_d = sum;
        idx_d = idx_q + 2'd1;
      end
    end
    // A partial average never spans IDLE, a stall or a clear.
    if (CLR || state_q == ST_IDLE || (state_q != ST_STALL && state_d == ST_STALL)) begin
      acc_d = '0;
      idx_d = '0;
    end
  end

  // Accumulator registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end
`else
  // Every capture is published as-is.
  always_comb begin
    publish = capture;
    pub_val = cnt_q;
  end
`endif

  // Output register with valid/ready handshake and sticky overrun.
  always_comb begin
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (publish) begin
      period_d = pub_val;
      valid_d  = 1'b1;
      if (valid_q && !PERIOD_READY) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && PERIOD_READY) begin
      valid_d = 1'b0;
    end
    if (CLR) begin
      period_d  = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stalled_q <= stalled_d;
    end
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = valid_q;
  assign OVERRUN      = overrun_q;
  assign STALLED      = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: reset, steady periods, overrun/clear, stall
// timing, fastest input rate and (with PERIOD_METER_AVG_EN) averaging.
`timescale 1ns/1ps

module tb_period_meter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CLR;
  logic        SIG_IN;
  logic        PERIOD_READY;
  logic [15:0] PERIOD;
  logic        PERIOD_VALID;
  logic        OVERRUN;
  logic        STALLED;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 CLK = ~CLK;

  period_meter #(
    .CNT_W      (16),
    .SYNC_STAGES(2),
    .TIMEOUT    (50000)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CLR         (CLR),
    .SIG_IN      (SIG_IN),
    .PERIOD      (PERIOD),
    .PERIOD_VALID(PERIOD_VALID),
    .PERIOD_READY(PERIOD_READY),
    .OVERRUN     (OVERRUN),
    .STALLED     (STALLED)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One full input period starting with a rising edge.
  task automatic square(input int p);
    SIG_IN = 1'b1;
    tick(p / 2);
    SIG_IN = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic do_reset;
    RST_N        = 1'b0;
    CLR          = 1'b0;
    SIG_IN       = 1'b0;
    PERIOD_READY = 1'b0;
    tick(3);
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_reset;
    RST_N = 1'b0; CLR = 1'b0; SIG_IN = 1'b0; PERIOD_READY = 1'b0;
    tick(2);
    vectors++; if (PERIOD !== 16'd0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", PERIOD); end
    vectors++; if (PERIOD_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", PERIOD_VALID); end
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", OVERRUN); end
    vectors++; if (STALLED !== 1'b0) begin miscompares++; $display("FAIL reset_stalled: got %b expected 0", STALLED); end
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_reset_in_measure;
    do_reset();
    square(10);
    square(10);
    vectors++; if (PERIOD_VALID !== 1'b1) begin miscompares++; $display("FAIL rim_pre_valid: got %b expected 1", PERIOD_VALID); end
    vectors++; if (PERIOD !== 16'd10) begin miscompares++; $display("FAIL rim_pre_period: got %0d expected 10", PERIOD); end
    #2 RST_N = 1'b0;
    #1;
    vectors++; if (PERIOD !== 16'd0) begin miscompares++; $display("FAIL rim_async_period: got %0d expected 0", PERIOD); end
    vectors++; if (PERIOD_VALID !== 1'b0) begin miscompares++; $display("FAIL rim_async_valid: got %b expected 0", PERIOD_VALID); end
    vectors++; if (OVERRUN !== 1'b0 || STALLED !== 1'b0) begin miscompares++; $display("FAIL rim_async_flags: got ovr=%b stl=%b expected 0 0", OVERRUN, STALLED); end
    tick(2);
    RST_N = 1'b1;
    tick(1);
    square(10);
    vectors++; if (PERIOD_VALID !== 1'b0) begin miscompares++; $display("FAIL rim_rearm_valid: got %b expected 0", PERIOD_VALID); end
    SIG_IN = 1'b1;
    tick(5);
    vectors++; if (PERIOD_VALID !== 1'b1 || PERIOD !== 16'd10) begin miscompares++; $display("FAIL rim_after_rearm: got valid=%b period=%0d expected 1 10", PERIOD_VALID, PERIOD); end
    SIG_IN = 1'b0;
  endtask

  task automatic test_square_4002;
    int nvalid = 0;
    int first  = -1;
    do_reset();
    PERIOD_READY = 1'b1;
    for (int c = 0; c < 12020; c++) begin
      if (PERIOD_VALID === 1'b1) begin
        nvalid++;
        if (first < 0) first = c;
        vectors++; if (PERIOD !== 16'd4002) begin miscompares++; $display("FAIL sq_period: got %0d expected 4002 at cycle %0d", PERIOD, c); end
      end
      SIG_IN = ((c % 4002) < 2001);
      tick(1);
    end
    vectors++; if (nvalid != 3) begin miscompares++; $display("FAIL sq_valid_count: got %0d expected 3", nvalid); end
    vectors++; if (first != 4005) begin miscompares++; $display("FAIL sq_first_valid: got cycle %0d expected 4005", first); end
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL sq_overrun: got %b expected 0", OVERRUN); end
    SIG_IN = 1'b0;
  endtask

  task automatic test_overrun_clr;
    do_reset();
    square(100);
    square(150);
    vectors++; if (PERIOD !== 16'd100 || PERIOD_VALID !== 1'b1 || OVERRUN !== 1'b0) begin miscompares++; $display("FAIL ovr_first: got period=%0d valid=%b ovr=%b expected 100 1 0", PERIOD, PERIOD_VALID, OVERRUN); end
    SIG_IN = 1'b1;
    tick(10);
    vectors++; if (PERIOD !== 16'd150) begin miscompares++; $display("FAIL ovr_period: got %0d expected 150", PERIOD); end
    vectors++; if (PERIOD_VALID !== 1'b1) begin miscompares++; $display("FAIL ovr_valid: got %b expected 1", PERIOD_VALID); end
    vectors++; if (OVERRUN !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b expected 1", OVERRUN); end
    SIG_IN = 1'b0;
    tick(5);
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    vectors++; if (OVERRUN !== 1'b0 || PERIOD_VALID !== 1'b0 || PERIOD !== 16'd0) begin miscompares++; $display("FAIL clr_outputs: got ovr=%b valid=%b period=%0d expected 0 0 0", OVERRUN, PERIOD_VALID, PERIOD); end
  endtask

  task automatic test_stall;
    do_reset();
    SIG_IN = 1'b1;
    for (int k = 1; k <= 50003; k++) begin
      tick(1);
      if (k == 10) SIG_IN = 1'b0;
      if (k == 50002) begin
        vectors++; if (STALLED !== 1'b0) begin miscompares++; $display("FAIL stall_early: got %b expected 0", STALLED); end
      end
      if (k == 50003) begin
        vectors++; if (STALLED !== 1'b1) begin miscompares++; $display("FAIL stall_set: got %b expected 1", STALLED); end
      end
    end
    square(300);
    vectors++; if (STALLED !== 1'b0 || PERIOD_VALID !== 1'b0) begin miscompares++; $display("FAIL stall_rearm: got stl=%b valid=%b expected 0 0", STALLED, PERIOD_VALID); end
    SIG_IN = 1'b1;
    tick(5);
    vectors++; if (PERIOD_VALID !== 1'b1 || PERIOD !== 16'd300) begin miscompares++; $display("FAIL stall_result: got valid=%b period=%0d expected 1 300", PERIOD_VALID, PERIOD); end
    SIG_IN = 1'b0;
  endtask

  task automatic test_fast_toggle;
    do_reset();
    PERIOD_READY = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i >= 5 && i < 40) begin
        if (i % 2 == 1) begin
          vectors++; if (PERIOD_VALID !== 1'b1 || PERIOD !== 16'd2) begin miscompares++; $display("FAIL fast_capture: got valid=%b period=%0d expected 1 2 at %0d", PERIOD_VALID, PERIOD, i); end
        end else begin
          vectors++; if (PERIOD_VALID !== 1'b0) begin miscompares++; $display("FAIL fast_consumed: got valid=%b expected 0 at %0d", PERIOD_VALID, i); end
        end
      end
      if (i >= 43) begin
        vectors++; if (PERIOD_VALID !== 1'b1 || PERIOD !== 16'd2) begin miscompares++; $display("FAIL fast_hold: got valid=%b period=%0d expected 1 2 at %0d", PERIOD_VALID, PERIOD, i); end
      end
      SIG_IN = ~SIG_IN;
      if (i >= 40) PERIOD_READY = (i % 2 == 0);
      tick(1);
    end
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL fast_overrun: got %b expected 0", OVERRUN); end
    SIG_IN = 1'b0;
    PERIOD_READY = 1'b0;
  endtask

  task automatic test_avg;
    do_reset();
    square(100);
    square(101);
    square(102);
    square(104);
    vectors++; if (PERIOD_VALID !== 1'b0) begin miscompares++; $display("FAIL avg_early_valid: got %b expected 0", PERIOD_VALID); end
    SIG_IN = 1'b1;
    tick(5);
    vectors++; if (PERIOD_VALID !== 1'b1) begin miscompares++; $display("FAIL avg_valid: got %b expected 1", PERIOD_VALID); end
    vectors++; if (PERIOD !== 16'd101) begin miscompares++; $display("FAIL avg_period: got %0d expected 101", PERIOD); end
    vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL avg_overrun: got %b expected 0", OVERRUN); end
    SIG_IN = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; CLR = 1'b0; SIG_IN = 1'b0; PERIOD_READY = 1'b0;
    test_reset();
`ifdef PERIOD_METER_AVG_EN
    test_avg();
`else
    test_reset_in_measure();
    test_square_4002();
    test_overrun_clr();
    test_stall();
    test_fast_toggle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
